// File: rtl/instr_sequencer.sv
// PIC16F-style Q-cycle instruction sequencer with hardware return stack.
// Define STACK_TRAP_EN to trap stack overflow/underflow and halt the core.
module instr_sequencer #(
    parameter int PC_WIDTH    = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [13:0]         instr_current,
    input  logic [PC_WIDTH-1:0] pc_current,
    input  logic                status_z,
    input  logic                bit_test_res,
    output logic [1:0]          q_count,
    output logic                alu_sel_l,
    output logic [3:0]          alu_op,
    output logic                alu_status_wr_en,
    output logic                f_wr_en,
    output logic                w_wr_en,
    output logic                instr_rd_en,
    output logic                instr_flush,
    output logic                pc_incr_en,
    output logic                pc_j_en,
    output logic                pc_ret_en,
    output logic [PC_WIDTH-1:0] stack_top,
    output logic                stack_err
);
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_COM    = 4'd5;
    localparam logic [3:0] ALU_RR     = 4'd6;
    localparam logic [3:0] ALU_RL     = 4'd7;
    localparam logic [3:0] ALU_SWAP   = 4'd8;
    localparam logic [3:0] ALU_BS     = 4'd9;
    localparam logic [3:0] ALU_BC     = 4'd10;
    localparam logic [3:0] ALU_INC    = 4'd11;
    localparam logic [3:0] ALU_DEC    = 4'd12;
    localparam logic [3:0] ALU_PASSLF = 4'd13;
    localparam logic [3:0] ALU_PASSW  = 4'd14;
    localparam logic [3:0] ALU_ZERO   = 4'd15;

    localparam logic [2:0] K_SEQ   = 3'd0;
    localparam logic [2:0] K_SKIPZ = 3'd1;
    localparam logic [2:0] K_SKIPB = 3'd2;
    localparam logic [2:0] K_JMP   = 3'd3;
    localparam logic [2:0] K_CALL  = 3'd4;
    localparam logic [2:0] K_RET   = 3'd5;

    localparam int SPW = $clog2(STACK_DEPTH);
    localparam int CW  = SPW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(STACK_DEPTH);

    logic [1:0]          r_q;
    logic [1:0]          w_q_nxt;
    logic [SPW-1:0]      r_sp;
    logic [CW-1:0]       r_count;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic                w_sel, w_st, w_f, w_w;
    logic [3:0]          w_op;
    logic [2:0]          w_k;
    logic                w_halt, w_push, w_pop, w_do_push, w_do_pop;
    logic [PC_WIDTH-1:0] w_ret_addr;

    // Q2 operand/op/write fields and Q3 flow kind per opcode
    always_comb begin
        w_sel = 1'b0;
        w_op  = ALU_ADD;
        w_st  = 1'b0;
        w_f   = 1'b0;
        w_w   = 1'b0;
        w_k   = K_SEQ;
        casez (instr_current)
            14'b00_0000_0000_1000: w_k = K_RET;
            14'b00_0000_1???_????: begin
                w_op = ALU_PASSW;
                w_f  = 1'b1;
            end
            14'b00_0000_????_????: ;
            14'b00_????_????_????: begin
                w_f  = instr_current[7];
                w_w  = ~instr_current[7];
                w_st = (instr_current[11:8] != 4'b1110);
                case (instr_current[11:8])
                    4'b0001: w_op = ALU_ZERO;
                    4'b0010: w_op = ALU_SUB;
                    4'b0011: w_op = ALU_DEC;
                    4'b0100: w_op = ALU_OR;
                    4'b0101: w_op = ALU_AND;
                    4'b0110: w_op = ALU_XOR;
                    4'b1000: w_op = ALU_PASSLF;
                    4'b1001: w_op = ALU_COM;
                    4'b1010: w_op = ALU_INC;
                    4'b1011: begin w_op = ALU_DEC; w_k = K_SKIPZ; end
                    4'b1100: w_op = ALU_RR;
                    4'b1101: w_op = ALU_RL;
                    4'b1110: w_op = ALU_SWAP;
                    4'b1111: begin w_op = ALU_INC; w_k = K_SKIPZ; end
                    default: w_op = ALU_ADD;
                endcase
            end
            14'b01_00??_????_????: begin w_op = ALU_BC; w_f = 1'b1; w_st = 1'b1; end
            14'b01_01??_????_????: begin w_op = ALU_BS; w_f = 1'b1; w_st = 1'b1; end
            14'b01_10??_????_????: begin w_op = ALU_BC; w_k = K_SKIPB; end
            14'b01_11??_????_????: begin w_op = ALU_BS; w_k = K_SKIPB; end
            14'b10_0???_????_????: w_k = K_CALL;
            14'b10_1???_????_????: w_k = K_JMP;
            14'b11_00??_????_????: begin w_sel = 1'b1; w_op = ALU_PASSLF; w_w = 1'b1; end
            14'b11_01??_????_????: begin
                w_sel = 1'b1;
                w_op  = ALU_PASSLF;
                w_w   = 1'b1;
                w_k   = K_RET;
            end
            14'b11_1000_????_????: begin w_sel = 1'b1; w_op = ALU_OR;  w_w = 1'b1; w_st = 1'b1; end
            14'b11_1001_????_????: begin w_sel = 1'b1; w_op = ALU_AND; w_w = 1'b1; w_st = 1'b1; end
            14'b11_1010_????_????: begin w_sel = 1'b1; w_op = ALU_XOR; w_w = 1'b1; w_st = 1'b1; end
            14'b11_110?_????_????: begin w_sel = 1'b1; w_op = ALU_SUB; w_w = 1'b1; w_st = 1'b1; end
            14'b11_111?_????_????: begin w_sel = 1'b1; w_op = ALU_ADD; w_w = 1'b1; w_st = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_q <= 2'd0;
        else     r_q <= w_q_nxt;
    end

    always_comb begin
        w_q_nxt = r_q + 2'd1;
    end

    always_comb begin
        alu_sel_l        = 1'b0;
        alu_op           = 4'd0;
        alu_status_wr_en = 1'b0;
        f_wr_en          = 1'b0;
        w_wr_en          = 1'b0;
        instr_rd_en      = 1'b0;
        instr_flush      = 1'b0;
        pc_incr_en       = 1'b0;
        pc_j_en          = 1'b0;
        pc_ret_en        = 1'b0;
        if (!w_halt) begin
            if (r_q == 2'd2) begin
                alu_sel_l        = w_sel;
                alu_op           = w_op;
                alu_status_wr_en = w_st;
                f_wr_en          = w_f;
                w_wr_en          = w_w;
            end else if (r_q == 2'd3) begin
                case (w_k)
                    K_SKIPZ: begin
                        instr_flush = status_z;
                        instr_rd_en = ~status_z;
                        pc_incr_en  = 1'b1;
                    end
                    K_SKIPB: begin
                        instr_flush = bit_test_res;
                        instr_rd_en = ~bit_test_res;
                        pc_incr_en  = 1'b1;
                    end
                    K_JMP, K_CALL: begin
                        instr_flush = 1'b1;
                        pc_j_en     = 1'b1;
                    end
                    K_RET: begin
                        instr_flush = 1'b1;
                        pc_ret_en   = 1'b1;
                    end
                    default: begin
                        instr_rd_en = 1'b1;
                        pc_incr_en  = 1'b1;
                    end
                endcase
            end
        end
    end

    assign q_count    = r_q;
    assign w_ret_addr = pc_current + PC_WIDTH'(1);
    assign w_push     = (r_q == 2'd3) && (w_k == K_CALL) && !w_halt;
    assign w_pop      = (r_q == 2'd3) && (w_k == K_RET) && !w_halt;

`ifdef STACK_TRAP_EN
    logic r_err;
    logic w_ovf, w_unf;
    assign w_ovf = w_push && (r_count == CNT_FULL);
    assign w_unf = w_pop && (r_count == '0);
    always_ff @(posedge clk) begin
        if (rst)                r_err <= 1'b0;
        else if (w_ovf | w_unf) r_err <= 1'b1;
    end
    assign w_halt    = r_err;
    assign w_do_push = w_push && !w_ovf;
    assign w_do_pop  = w_pop && !w_unf;
`else
    assign w_halt    = 1'b0;
    assign w_do_push = w_push;
    assign w_do_pop  = w_pop;
`endif
    assign stack_err = w_halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SPW'(1);
            if (r_count != CNT_FULL) r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_sp <= r_sp - SPW'(1);
            if (r_count != '0) r_count <= r_count - CW'(1);
        end
    end

    // Entries are deliberately left unreset
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_stack[r_sp] <= w_ret_addr;
    end

    assign stack_top = r_stack[r_sp - SPW'(1)];
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// Covers the trap path when built with STACK_TRAP_EN.
module tb_instr_sequencer;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, BC = 4'd10, DEC = 4'd12;
    localparam logic [3:0] PASSLF = 4'd13, PASSW = 4'd14, ZERO = 4'd15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] instr_current = 14'h0000;
    logic [12:0] pc_current = 13'h0;
    logic        status_z = 1'b0;
    logic        bit_test_res = 1'b0;
    logic [1:0]  q_count;
    logic        alu_sel_l, alu_status_wr_en, f_wr_en, w_wr_en;
    logic [3:0]  alu_op;
    logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_ret_en;
    logic [12:0] stack_top;
    logic        stack_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [12:0] c [4];
    logic [1:0]  qs [4];
    logic [12:0] top3;

    instr_sequencer #(.PC_WIDTH(13), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .instr_current(instr_current), .pc_current(pc_current),
        .status_z(status_z), .bit_test_res(bit_test_res),
        .q_count(q_count), .alu_sel_l(alu_sel_l), .alu_op(alu_op),
        .alu_status_wr_en(alu_status_wr_en),
        .f_wr_en(f_wr_en), .w_wr_en(w_wr_en),
        .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
        .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en), .pc_ret_en(pc_ret_en),
        .stack_top(stack_top), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] E(input logic sel, input logic [3:0] op,
        input logic st, input logic f, input logic w, input logic rd,
        input logic fl, input logic inc, input logic j, input logic ret);
        return {sel, op, st, f, w, rd, fl, inc, j, ret};
    endfunction

    function automatic logic [12:0] ctl_now();
        return {alu_sel_l, alu_op, alu_status_wr_en, f_wr_en, w_wr_en,
                instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_ret_en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at Q0 (1 time unit after the edge); leaves at the next Q0
    task automatic run(input logic [13:0] ins, input logic [12:0] pc);
        instr_current = ins;
        pc_current = pc;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            c[p] = ctl_now();
            qs[p] = q_count;
            if (p == 3) top3 = stack_top;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic slot(input string tag, input logic [13:0] ins, input logic [12:0] pc,
        input logic [12:0] e2, input logic [12:0] e3);
        run(ins, pc);
        chk({tag, ".q"}, {qs[0], qs[1], qs[2], qs[3]}, 8'h1B);
        chk({tag, ".q0"}, c[0], 13'h0);
        chk({tag, ".q1"}, c[1], 13'h0);
        chk({tag, ".q2"}, c[2], e2);
        chk({tag, ".q3"}, c[3], e3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] seq, jmp, rtn, halt0;
        seq = E(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        jmp = E(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        rtn = E(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        halt0 = 13'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.q", q_count, 2'd0);
        chk("rst.ctl", ctl_now(), 13'h0);
        chk("rst.err", stack_err, 1'b0);
        chk("rst.count", dut.r_count, 4'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        slot("movlw", 14'h3005, 13'h000, E(1, PASSLF, 0, 0, 1, 0, 0, 0, 0, 0), seq);
        slot("addlw", 14'h3E03, 13'h001, E(1, ADD, 1, 0, 1, 0, 0, 0, 0, 0), seq);
        slot("addwf", 14'h07A0, 13'h002, E(0, ADD, 1, 1, 0, 0, 0, 0, 0, 0), seq);
        slot("clrw", 14'h0103, 13'h003, E(0, ZERO, 1, 0, 1, 0, 0, 0, 0, 0), seq);
        slot("movwf", 14'h00A0, 13'h004, E(0, PASSW, 0, 1, 0, 0, 0, 0, 0, 0), seq);
        slot("sublw", 14'h3C10, 13'h005, E(1, SUB, 1, 0, 1, 0, 0, 0, 0, 0), seq);
        slot("clrwdt", 14'h0064, 13'h006, 13'h0, seq);
        bit_test_res = 1'b1;
        slot("btfsc1", 14'h1820, 13'h007, E(0, BC, 0, 0, 0, 0, 0, 0, 0, 0),
             E(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        bit_test_res = 1'b0;
        slot("btfsc0", 14'h1820, 13'h008, E(0, BC, 0, 0, 0, 0, 0, 0, 0, 0), seq);
        status_z = 1'b1;
        slot("decfsz", 14'h0BA0, 13'h009, E(0, DEC, 1, 1, 0, 0, 0, 0, 0, 0),
             E(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        status_z = 1'b0;
        slot("goto", 14'h2805, 13'h00A, 13'h0, jmp);

        slot("call", 14'h2050, 13'h010, 13'h0, jmp);
        chk("call.count", dut.r_count, 4'd1);
        slot("return", 14'h0008, 13'h050, 13'h0, rtn);
        chk("return.top", top3, 13'h011);
        chk("return.count", dut.r_count, 4'd0);
        slot("retlw", 14'h3400, 13'h060, E(1, PASSLF, 0, 0, 1, 0, 0, 0, 0, 0), rtn);

        instr_current = 14'h2050;
        pc_current = 13'h020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstq2.count", dut.r_count, 4'd0);
        slot("rstq2.nop", 14'h0000, 13'h000, 13'h0, seq);

        instr_current = 14'h2050;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstq3.count", dut.r_count, 4'd0);
        slot("rstq3.nop", 14'h0000, 13'h000, 13'h0, seq);

        for (int i = 0; i < 9; i++)
            slot($sformatf("ovf.call%0d", i), 14'h2200, 13'h100 + 13'(i), 13'h0, jmp);
`ifdef STACK_TRAP_EN
        chk("trap.err", stack_err, 1'b1);
        chk("trap.count", dut.r_count, 4'd8);
        slot("trap.halt", 14'h3005, 13'h200, halt0, halt0);
        chk("trap.top", top3, 13'h108);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("trap.clr", stack_err, 1'b0);
        chk("trap.clrcnt", dut.r_count, 4'd0);
        slot("trap.resume", 14'h3005, 13'h000, E(1, PASSLF, 0, 0, 1, 0, 0, 0, 0, 0), seq);
`else
        chk("ovf.err", stack_err, 1'b0);
        chk("ovf.count", dut.r_count, 4'd8);
        chk("ovf.halt", halt0, 13'h0 & ctl_now());
        for (int k = 0; k < 9; k++) begin
            slot($sformatf("ovf.ret%0d", k), 14'h0008, 13'h300, 13'h0, rtn);
            chk($sformatf("ovf.top%0d", k), top3,
                (k == 8) ? 13'h109 : 13'h109 - 13'(k));
        end
        chk("unf.count", dut.r_count, 4'd0);
        chk("unf.err", stack_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Parametrised successor to the single-level PIC16F instruction decoder.
- Runs the four-Q-cycle execute sequence and drives ALU and register-write strobes.
- Adds literal ALU ops, CALL/RETURN/RETLW and a hardware return stack of configurable depth with occupancy tracking.
- Sits between the instruction register, PC, ALU/status and register file.

## Interface

Parameters:
- PC_WIDTH, 13, program counter width.
- STACK_DEPTH, 8, return-stack entries; power of two, 2..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instr_current  in  14  instruction being executed.
- pc_current  in  PC_WIDTH  PC of instr_current.
- status_z  in  1  ALU zero status.
- bit_test_res  in  1  bit-test result (1 = skip).
- q_count  out  2  current Q phase.
- alu_sel_l  out  1  ALU B operand: 1 = literal, 0 = f.
- alu_op  out  4  ALU operation, encodings from alu_ops.vh.
- alu_status_wr_en  out  1  write status flags.
- f_wr_en, w_wr_en  out  1 each  register write strobes.
- instr_rd_en  out  1  load next instruction.
- instr_flush  out  1  load NOP instead of next instruction.
- pc_incr_en  out  1  PC <= PC+1.
- pc_j_en  out  1  PC <= jump address from instruction.
- pc_ret_en  out  1  PC <= stack_top.
- stack_top  out  PC_WIDTH  return address at top of stack.
- stack_err  out  1  sticky overflow/underflow flag (see Configuration).

## Operation

- **Q counter:** q_count counts 0→1→2→3→0 and wraps freely.
- **Strobes:** all strobes are combinational from instr_current, q_count and state, and default to 0.
  - Q2: ALU/write strobes.
  - Q3: fetch/PC strobes.
- **Byte ops:** ADDWF, ANDWF, CLRF, CLRW, COMF, DECF, INCF, IORWF, MOVF, RLF, RRF, SUBWF, XORWF.
  - Q2: alu_sel_l=0, op per mnemonic, alu_status_wr_en=1; d=instr[7] selects f_wr_en (1) or w_wr_en (0).
  - Q3: instr_rd_en=1, pc_incr_en=1.
- **MOVWF:** Q2 op passw, f_wr_en=1, no status write.
- **SWAPF:** Q2 as a byte op but alu_status_wr_en=0.
- **BCF/BSF:** Q2 op bc/bs, f_wr_en=1, status write enabled.
- **DECFSZ/INCFSZ:** Q2 as a byte op. Q3: instr_flush=status_z, instr_rd_en=~status_z, pc_incr_en=1.
- **BTFSC/BTFSS:** Q2 op bc/bs with no writes. Q3: flush=bit_test_res, rd=~bit_test_res, pc_incr_en=1.
- **Literal ops:** MOVLW, ADDLW, ANDLW, IORLW, SUBLW, XORLW.
  - Q2: alu_sel_l=1, op passlf/add/and/or/sub/xor, w_wr_en=1; status written except for MOVLW.
  - Q3: rd + incr.
- **NOP:** Q3 rd + incr.
- **GOTO:** Q3 instr_flush=1, pc_j_en=1.
- **CALL:** Q3 pushes pc_current+1 (PC_WIDTH arithmetic, wraps), then instr_flush=1, pc_j_en=1.
- **RETURN:** Q3 pops; instr_flush=1, pc_ret_en=1.
- **RETLW:** Q2 as MOVLW; Q3 as RETURN.
- **Unrecognised opcodes:** treated as NOP.
- **Stack pointer:** sp has width $clog2(STACK_DEPTH) and wraps modulo depth.
  - Push writes stack[sp] then sp+1.
  - Pop does sp-1.
  - stack_top = stack[sp-1] (combinational).
- **Occupancy:** count has width $clog2(STACK_DEPTH)+1, saturating at 0 and STACK_DEPTH; it detects overflow (push at full) and underflow (pop at empty).
- **Stack memory:** contents are not reset.

## Timing

- Every instruction takes 4 clocks.
- A taken skip or any jump/call/return flushes, so the next slot executes a NOP: 8 clocks total.
- Push/pop take effect on the clk edge ending Q3. stack_top is valid throughout Q3 of RETURN/RETLW.
- **On rst:**
  - q_count=0, sp=0, count=0, stack_err=0.
  - All strobes 0 except those decoded for Q0, which is none.
- Reset mid-instruction aborts it with no push/pop.
- rst has priority over a Q3 push/pop in the same cycle.

## Configuration

- **STACK_TRAP_EN undefined (PIC-compatible):**
  - Overflow overwrites the oldest entry (sp wraps).
  - Underflow returns stale stack[sp-1].
  - stack_err is tied 0.
- **STACK_TRAP_EN defined:**
  - Overflow or underflow sets stack_err (sticky until rst) and suppresses that push/pop.
  - From the following cycle, all strobe outputs are forced 0 (core halts) until rst.

## Test plan

- MOVLW 0x05 then ADDLW 0x03 → Q2 of ADDLW: alu_sel_l=1, alu_op=add, w_wr_en=1, alu_status_wr_en=1; Q3: pc_incr_en=1.
- CALL at pc=0x010, then RETURN → push 0x011; CALL Q3 has pc_j_en=1 and flush=1. RETURN Q3: stack_top=0x011, pc_ret_en=1, instr_flush=1; count back to 0.
- BTFSC with bit_test_res=1 → Q3: instr_flush=1, instr_rd_en=0, pc_incr_en=1. With bit_test_res=0 → rd=1, flush=0.
- STACK_DEPTH=8, trap off, 9 CALLs from pc 0x100.. then 9 RETURNs → first return yields last pushed+1, eighth yields the second call's address, ninth repeats; stack_err=0.
- Trap on, 9 CALLs → stack_err=1 after the 9th CALL Q3, all strobes 0 afterwards, sp unchanged at 0 (8 entries); rst clears stack_err and resumes.
- rst asserted at Q2 of CALL → no push, q_count=0 next cycle, count=0, all strobes 0.
